async_fifo_rd_ctrl: RTL and testbench
=====================================

# async_fifo_rd_ctrl

Read-side pointer controller for the asynchronous FIFO. It sits directly downstream of the write-domain Gray/binary pointer counter. It takes that counter's Gray-coded write pointer across the clock boundary and converts it to binary. From it, the block generates the read-domain empty flag, occupancy level and RAM read address, and returns its own Gray-coded read pointer for the write side to synchronise.

## Interface
Parameters:
- W_ADDR, default 4: log2 of FIFO depth. Pointers are W_ADDR+1 bits wide.
- SYNC_STAGES, default 2: flop stages in the write-pointer synchroniser. Legal values are 2 or more.

Ports:
- clk  in  1: read-domain clock.
- rst_n  in  1: reset, asynchronous, active-low.
- wptr_gry_async  in  W_ADDR+1: Gray write pointer from the write-domain counter. Asynchronous to clk.
- rd_en  in  1: pop request.
- empty  out  1: FIFO empty. Registered.
- level  out  W_ADDR+1: entries currently readable, range 0 to 2^W_ADDR. Registered.
- raddr  out  W_ADDR: RAM address of the head entry.
- rptr_gry  out  W_ADDR+1: Gray read pointer, to the write-domain synchroniser. Registered directly, with no logic after the flop.
- underflow  out  1: sticky pop-while-empty flag. See Configuration.

## Operation
- The synchroniser is a chain of SYNC_STAGES flops on wptr_gry_async and is the only logic on that input. The final stage is wsync_gry.
- Gray-to-binary conversion: wsync_bin[i] = XOR of wsync_gry[W_ADDR:i].
- The read pointer is held in two registers, rptr_bin and rptr_gry, both W_ADDR+1 bits.
- pop = rd_en & !empty. On pop, rptr_bin increments by 1 and rptr_gry is loaded with bin2gray(rptr_bin+1).
- A pop with rd_en=1 while empty=1 has no effect on the pointers.
- raddr = rptr_bin[W_ADDR-1:0] (the current head). It changes only on an accepted pop.
- Next-state values:
  - rptr_next = rptr_bin + pop.
  - empty_next = (wsync_gry == bin2gray(rptr_next)).
  - level_next = (wsync_bin - rptr_next) mod 2^(W_ADDR+1).
- Wrap-around: pointers wrap modulo 2^(W_ADDR+1) with no special case. Full occupancy reports level = 2^W_ADDR, with pointer MSBs differing and the lower bits equal.
- Reset values: all synchroniser flops 0, rptr_bin 0, rptr_gry 0, raddr 0, empty 1, level 0, underflow 0.
- Reset applied mid-operation returns the block to the reset state immediately, without waiting for a clock edge. The write side must be reset in the same event; the FIFO does not support a reset of one side only.
- A pop and a wsync_gry change in the same cycle are both applied to empty_next and level_next.

## Timing
- Write visibility: suppose a wptr_gry_async change meets setup at edge E. Then empty and level reflect it after edge E+SYNC_STAGES. With the default SYNC_STAGES=2, that is 3 edges including E.
- Pop: on the edge that accepts a pop, raddr, rptr_gry, empty and level all update together.
- Back-to-back pops at one per cycle are supported while empty=0.
- empty is pessimistic. It may stay asserted for up to SYNC_STAGES+1 cycles after data has been written, and it is never deasserted while the FIFO holds no data.
- The source of wptr_gry_async must change by at most one bit per write-clock edge.

## Configuration
- Macro: ASYNC_FIFO_RD_UNDERFLOW_CHK_EN.
- Defined:
  - underflow is set on any edge where rd_en=1 and empty=1.
  - underflow stays set until rst_n is asserted.
  - A simulation-only assertion also fires at that edge.
- Undefined:
  - underflow is tied to 0, and no flop or assertion is generated.
  - Pop gating on empty is unchanged.

## Structure
- Shared package async_fifo_pkg holds:
  - the bin2gray and gray2bin functions (parameterised width);
  - the constant ASYNC_FIFO_SYNC_STAGES_DEFAULT = 2.
- The write-side controller uses the same package.
- One sub-module, gray_ptr_sync: an N-stage, W-bit flop chain on the Gray bus with a fixed reset value of 0. It carries synthesis keep and no-retiming attributes on every stage and is reused for rptr_gry on the write side.

## Test plan
1. **Reset:** assert rst_n=0 mid-stream with level=5 → empty=1, level=0, raddr=0, rptr_gry=0 immediately. After release, no spurious pop occurs.
2. **Write latency:** step wptr_gry_async 00000→00001 just before edge E → empty stays 1 through edge E+1. After edge E+2: empty=0 and level=1.
3. **Fill to full:** drive the Gray sequence for 16 writes (final value 11000) → level=16 and empty=0. Pop 16 times back-to-back → raddr steps 0..15, level decrements each edge, empty=1 after the 16th pop.
4. **Underflow:** with empty=1, hold rd_en=1 for 3 cycles → rptr_gry unchanged. With the macro defined, underflow=1 from the first edge. Without it, underflow stays 0.
5. **Wrap:** advance both pointers through 31→0 (Gray 10000→00000) using 40 write/pop pairs → level never exceeds 16 or underflows, and raddr wraps 15→0.
6. **Simultaneous events:** level=1, pop accepted on the same edge that a new wptr arrives at wsync_gry → level stays 1, empty stays 0, raddr increments by 1.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_pkg
// Helpers shared by the read-side and write-side controllers of the
// asynchronous FIFO.
//   bin2gray / gray2bin : pointer code conversions. They work on any width up
//                         to 32 bits. Zero-extend the pointer on the way in and
//                         cast the result back to the pointer width. Zero
//                         upper bits do not change the low bits of either
//                         conversion.
//   ASYNC_FIFO_SYNC_STAGES_DEFAULT : default depth of a pointer synchroniser.
// -----------------------------------------------------------------------------
package async_fifo_pkg;

  localparam int ASYNC_FIFO_SYNC_STAGES_DEFAULT = 2;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Bit i of the binary value is the XOR of all Gray bits at or above i.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage : async_fifo_pkg

// File: rtl/gray_ptr_sync.sv
// -----------------------------------------------------------------------------
// gray_ptr_sync
// An N-stage, W-bit flop chain that carries a Gray-coded pointer into the clk
// domain. Every stage resets to 0. There is no logic between the stages.
// Every stage is marked so that synthesis keeps it and does not retime it.
// The write side reuses this module for the read pointer.
//   clk   : destination-domain clock
//   rst_n : asynchronous active-low reset
//   d_i   : Gray pointer from the other clock domain
//   q_o   : synchronised Gray pointer (final stage)
// -----------------------------------------------------------------------------
module gray_ptr_sync #(
  parameter int W = 5,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  (* keep = "true", async_reg = "true", dont_retime = "true" *)
  logic [W-1:0] stage_q [N];

  // NOTE: every stage is reset. These are ordinary flops, not a RAM, so the
  // reset is cheap, and it guarantees a known all-zero pointer after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[N-1];

endmodule : gray_ptr_sync

// File: rtl/async_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// async_fifo_rd_ctrl
// Read-side pointer controller of the asynchronous FIFO.
//   - Synchronises the write Gray pointer and converts it to binary.
//   - Keeps the read pointer in binary and Gray form.
//   - Produces the registered empty and level outputs.
//   - Returns the Gray read pointer straight from a flop.
// Parameters:
//   W_ADDR      : log2 of FIFO depth; pointers are W_ADDR+1 bits
//   SYNC_STAGES : write-pointer synchroniser depth (>= 2)
// Ports:
//   clk, rst_n     : read clock, asynchronous active-low reset
//   wptr_gry_async : Gray write pointer, asynchronous to clk
//   rd_en          : pop request; ignored while empty
//   empty, level   : registered empty flag and readable entry count
//   raddr          : RAM address of the head entry
//   rptr_gry       : registered Gray read pointer for the write side
//   underflow      : sticky pop-while-empty flag. It is only built when
//                    ASYNC_FIFO_RD_UNDERFLOW_CHK_EN is defined; otherwise it
//                    is tied to 0.
// -----------------------------------------------------------------------------
module async_fifo_rd_ctrl
  import async_fifo_pkg::*;
#(
  parameter int W_ADDR      = 4,
  parameter int SYNC_STAGES = ASYNC_FIFO_SYNC_STAGES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_ADDR:0]   wptr_gry_async,
  input  logic              rd_en,
  output logic              empty,
  output logic [W_ADDR:0]   level,
  output logic [W_ADDR-1:0] raddr,
  output logic [W_ADDR:0]   rptr_gry,
  output logic              underflow
);

  localparam int PW = W_ADDR + 1;
  typedef logic [PW-1:0] ptr_t;

  ptr_t wsync_gry, wsync_bin;
  ptr_t rptr_bin_q, rptr_bin_d;
  ptr_t rptr_gry_q, rptr_gry_d;
  ptr_t level_q, level_d;
  logic empty_q, empty_d;
  logic pop;

  gray_ptr_sync #(
    .W (PW),
    .N (SYNC_STAGES)
  ) u_wptr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (wptr_gry_async),
    .q_o   (wsync_gry)
  );

  assign wsync_bin = ptr_t'(gray2bin(32'(wsync_gry)));

  // A pop is only accepted against the registered empty flag. An accepted pop
  // and a newly synchronised write pointer both feed the same next-state
  // values.
  assign pop        = rd_en & ~empty_q;
  assign rptr_bin_d = rptr_bin_q + ptr_t'(pop);
  assign rptr_gry_d = ptr_t'(bin2gray(32'(rptr_bin_d)));
  assign empty_d    = (wsync_gry == rptr_gry_d);
  // Modular subtraction gives the count directly, including full (2^W_ADDR)
  // and across pointer wrap.
  assign level_d    = wsync_bin - rptr_bin_d;

  // NOTE: state flops use non-blocking assignments, so every register samples
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_bin_q <= '0;
      rptr_gry_q <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
    end else begin
      rptr_bin_q <= rptr_bin_d;
      rptr_gry_q <= rptr_gry_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
    end
  end

  assign empty    = empty_q;
  assign level    = level_q;
  assign raddr    = rptr_bin_q[W_ADDR-1:0];
  assign rptr_gry = rptr_gry_q;

`ifdef ASYNC_FIFO_RD_UNDERFLOW_CHK_EN
  logic underflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) underflow_q <= 1'b0;
    else        underflow_q <= underflow_q | (rd_en & empty_q);
  end

  assign underflow = underflow_q;

`ifndef SYNTHESIS
  underflow_a : assert property (@(posedge clk) disable iff (!rst_n) !(rd_en && empty_q))
    else $warning("async_fifo_rd_ctrl: pop requested while empty");
`endif
`else
  assign underflow = 1'b0;
`endif

endmodule : async_fifo_rd_ctrl

// File: tb/tb_async_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_async_fifo_rd_ctrl
// Self-checking bench for async_fifo_rd_ctrl with default parameters.
// The reference model tracks the write count, the read count and a queue of
// write pointers in flight through the synchroniser. level and empty are
// derived from plain modular arithmetic on those counts.
// -----------------------------------------------------------------------------
module tb_async_fifo_rd_ctrl;

  localparam int W_ADDR  = 4;
  localparam int SYNC    = 2;
  localparam int DEPTH   = 1 << W_ADDR;
  localparam int PTR_MOD = 1 << (W_ADDR + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [W_ADDR:0]   wptr_gry_async;
  logic              rd_en;
  logic              empty;
  logic [W_ADDR:0]   level;
  logic [W_ADDR-1:0] raddr;
  logic [W_ADDR:0]   rptr_gry;
  logic              underflow;

  async_fifo_rd_ctrl #(
    .W_ADDR      (W_ADDR),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wptr_gry_async (wptr_gry_async),
    .rd_en          (rd_en),
    .empty          (empty),
    .level          (level),
    .raddr          (raddr),
    .rptr_gry       (rptr_gry),
    .underflow      (underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  int wcnt;        // write-side binary pointer currently driven
  int m_rd;        // read pointer (binary, mod PTR_MOD)
  int m_vis;       // write pointer as seen by the read domain
  int m_level;
  bit m_empty;
  bit m_uf;
  int hist[$];     // write pointers in flight through the synchroniser

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    wcnt    = 0;
    m_rd    = 0;
    m_vis   = 0;
    m_level = 0;
    m_empty = 1'b1;
    m_uf    = 1'b0;
    hist.delete();
  endtask

  task automatic check_model(input string tag);
    check({tag, ".empty"}, int'(empty), int'(m_empty));
    check({tag, ".level"}, int'(level), m_level);
    check({tag, ".raddr"}, int'(raddr), m_rd % DEPTH);
    check({tag, ".rptr_gry"}, int'(rptr_gry), gray(m_rd));
`ifdef ASYNC_FIFO_RD_UNDERFLOW_CHK_EN
    check({tag, ".underflow"}, int'(underflow), int'(m_uf));
`else
    check({tag, ".underflow"}, int'(underflow), 0);
`endif
  endtask

  // One clock: optionally advance the write pointer, request a pop, update
  // the model at the edge and compare 1 time unit later.
  task automatic tick(input bit rd, input bit wr, input string tag);
    bit pop_ok;
    if (wr) wcnt = (wcnt + 1) % PTR_MOD;
    wptr_gry_async = (W_ADDR+1)'(gray(wcnt));
    rd_en          = rd;
    @(posedge clk);
    pop_ok = rd && !m_empty;
    if (rd && m_empty) m_uf = 1'b1;
    if (pop_ok) m_rd = (m_rd + 1) % PTR_MOD;
    hist.push_back(wcnt);
    if (hist.size() > SYNC) m_vis = hist.pop_front();
    m_level = (m_vis + PTR_MOD - m_rd) % PTR_MOD;
    m_empty = (m_level == 0);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    bit rd;
    bit wr;
    bit exp_empty;
    int exp_level;
    int exp_raddr;
    int exp_rgry;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit wrapped;
    int prev_raddr;
    int g0;

    // Hand-derived sequence starting from reset (SYNC = 2). Rows 4-5 include
    // a pop on the same edge that a new write pointer becomes visible.
    vecs[0] = '{rd: 0, wr: 1, exp_empty: 1, exp_level: 0, exp_raddr: 0, exp_rgry: 0};
    vecs[1] = '{rd: 1, wr: 0, exp_empty: 1, exp_level: 0, exp_raddr: 0, exp_rgry: 0};
    vecs[2] = '{rd: 0, wr: 1, exp_empty: 0, exp_level: 1, exp_raddr: 0, exp_rgry: 0};
    vecs[3] = '{rd: 0, wr: 0, exp_empty: 0, exp_level: 1, exp_raddr: 0, exp_rgry: 0};
    vecs[4] = '{rd: 1, wr: 0, exp_empty: 0, exp_level: 1, exp_raddr: 1, exp_rgry: 1};
    vecs[5] = '{rd: 1, wr: 0, exp_empty: 1, exp_level: 0, exp_raddr: 2, exp_rgry: 3};
    vecs[6] = '{rd: 1, wr: 0, exp_empty: 1, exp_level: 0, exp_raddr: 2, exp_rgry: 3};

    // ---------------- reset ----------------
    model_reset();
    rst_n          = 1'b0;
    rd_en          = 1'b0;
    wptr_gry_async = '0;
    #12;
    check("rst.empty", int'(empty), 1);
    check("rst.level", int'(level), 0);
    check("rst.raddr", int'(raddr), 0);
    check("rst.rptr_gry", int'(rptr_gry), 0);
    check("rst.underflow", int'(underflow), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // ---------------- table vectors ----------------
    for (int i = 0; i < 7; i++) begin
      tick(vecs[i].rd, vecs[i].wr, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.tbl_empty", i), int'(empty), int'(vecs[i].exp_empty));
      check($sformatf("vec%0d.tbl_level", i), int'(level), vecs[i].exp_level);
      check($sformatf("vec%0d.tbl_raddr", i), int'(raddr), vecs[i].exp_raddr);
      check($sformatf("vec%0d.tbl_rgry", i), int'(rptr_gry), vecs[i].exp_rgry);
    end

    // ---------------- write latency: visible after E+2 ----------------
    tick(0, 1, "lat_E");
    check("lat_E.empty", int'(empty), 1);
    tick(0, 0, "lat_E1");
    check("lat_E1.empty", int'(empty), 1);
    tick(0, 0, "lat_E2");
    check("lat_E2.empty", int'(empty), 0);
    check("lat_E2.level", int'(level), 1);

    // ---------------- mid-stream reset with level = 5 ----------------
    repeat (4) tick(0, 1, "pre_rst_wr");
    repeat (SYNC + 1) tick(0, 0, "pre_rst_idle");
    check("pre_rst.level", int'(level), 5);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.empty", int'(empty), 1);
    check("async_rst.level", int'(level), 0);
    check("async_rst.raddr", int'(raddr), 0);
    check("async_rst.rptr_gry", int'(rptr_gry), 0);
    model_reset();
    wptr_gry_async = '0;
    rd_en          = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) tick(0, 0, "post_rst");
    check("post_rst.raddr", int'(raddr), 0);

    // ---------------- fill to full, then drain ----------------
    repeat (DEPTH) tick(0, 1, "fill");
    check("fill.wptr_gray", int'(wptr_gry_async), 5'b11000);
    repeat (SYNC + 1) tick(0, 0, "fill_idle");
    check("full.level", int'(level), DEPTH);
    check("full.empty", int'(empty), 0);
    for (int k = 1; k <= DEPTH; k++) begin
      tick(1, 0, "drain");
      check("drain.raddr", int'(raddr), k % DEPTH);
      check("drain.level", int'(level), DEPTH - k);
    end
    check("drained.empty", int'(empty), 1);

    // ---------------- wrap through 31 -> 0 ----------------
    wrapped = 1'b0;
    for (int k = 0; k < 40; k++) begin
      prev_raddr = int'(raddr);
      tick(1, 1, "wrap");
      check("wrap.level_bound", int'(level <= DEPTH), 1);
      if (prev_raddr == DEPTH - 1 && raddr == 0) wrapped = 1'b1;
    end
    check("wrap.raddr_wrapped", int'(wrapped), 1);

    // ---------------- underflow ----------------
    repeat (SYNC + 2) tick(1, 0, "uf_drain");
    check("uf.pre_empty", int'(empty), 1);
    g0 = int'(rptr_gry);
    for (int k = 0; k < 3; k++) begin
      tick(1, 0, "uf");
      check("uf.rptr_hold", int'(rptr_gry), g0);
`ifdef ASYNC_FIFO_RD_UNDERFLOW_CHK_EN
      check("uf.flag", int'(underflow), 1);
`else
      check("uf.flag", int'(underflow), 0);
`endif
    end

    // ---------------- randomized traffic ----------------
    for (int k = 0; k < 1500; k++) begin
      int occ;
      bit wr;
      occ = (wcnt + PTR_MOD - m_rd) % PTR_MOD;
      wr  = ($urandom_range(0, 2) != 0) && (occ < DEPTH);
      tick(bit'($urandom_range(0, 1)), wr, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_async_fifo_rd_ctrl
